// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Wraps mod 2^32; the low two bits are untouched because PC_STEP is word-aligned.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry {instr, pc} FIFO between instruction memory and the IF/ID register.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [CW-1:0]      count_o,
  output logic               head_valid_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [ADDR_W-1:0]  head_pc_o
);

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CW'(1);
    end
  end

  // A push into a full queue is only legal together with a pop; the slot written
  // is the head being consumed this same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= NOP_INSTR;
        pc_q[i]    <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        instr_q[wr_ptr_q] <= instr_i;
        pc_q[wr_ptr_q]    <= pc_i;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != '0);
  assign head_instr_o = instr_q[rd_ptr_q];
  assign head_pc_o    = pc_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, imem req/ack sequencing, redirect and stall absorption.
//   state   | meaning
//   IDLE    | no request outstanding
//   WAIT    | request outstanding, response will be queued
//   DISCARD | request outstanding, response belongs to a squashed path
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc,
  output logic [ADDR_W-1:0]  pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     queue_count, count_next;
  logic              push, pop, room;

  assign pop  = inst_valid & ~stall & ~redirect;
  assign push = (state_q == WAIT) & imem_ack & ~redirect;

  always_comb begin
    count_next = queue_count;
    if (redirect) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = queue_count + CW'(1);
    end else if (pop && !push) begin
      count_next = queue_count - CW'(1);
    end
  end

  // Issuing only while count_next < DEPTH keeps count + outstanding within DEPTH.
  assign room = (count_next < CW'(DEPTH));

  // addr_q is the address of the request on the bus; it diverges from fetch_pc_q
  // only in DISCARD, where the squashed request must stay stable until its ack.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          state_d    = WAIT;
          fetch_pc_d = redirect_pc;
          addr_d     = redirect_pc;
        end else if (room) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (imem_ack) begin
            addr_d = redirect_pc;
          end else begin
            state_d = DISCARD;
          end
        end else if (imem_ack) begin
          fetch_pc_d = pc_inc(fetch_pc_q);
          addr_d     = fetch_pc_d;
          state_d    = room ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = WAIT;
          addr_d  = fetch_pc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i        (clk),
    .rst_ni       (rst),
    .push_i       (push),
    .instr_i      (imem_rdata),
    .pc_i         (addr_q),
    .pop_i        (pop),
    .flush_i      (redirect),
    .count_o      (queue_count),
    .head_valid_o (inst_valid),
    .head_instr_o (inst),
    .head_pc_o    (inst_pc)
  );

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;
  assign pc_plus4  = pc_inc(inst_pc);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait fetch, stall, slow ack, redirects, PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        ack_en;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Memory model: ack whenever enabled and requested; each word tagged by its address.
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = imem_ack ? (imem_addr ^ 32'h1234_0000) : 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc_plus4    (pc_plus4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ack_en = 1'b0;
    #3;
    chk("rst_req",   32'(imem_req),   32'd0);
    chk("rst_addr",  imem_addr,       32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst",  inst,            32'h0);
    chk("rst_pc",    inst_pc,         32'h0);
    chk("rst_pc4",   pc_plus4,        32'h4);

    // Zero-wait memory after reset release
    @(negedge clk); rst = 1'b1; ack_en = 1'b1;
    tick();
    chk("e1_req",   32'(imem_req),   32'd1);
    chk("e1_addr",  imem_addr,       32'h0);
    chk("e1_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("e2_valid", 32'(inst_valid), 32'd1);
    chk("e2_pc",    inst_pc,         32'h0);
    chk("e2_inst",  inst,            32'h1234_0000);
    chk("e2_addr",  imem_addr,       32'h4);
    tick();
    chk("e3_pc",    inst_pc,         32'h4);
    chk("e3_pc4",   pc_plus4,        32'h8);
    chk("e3_addr",  imem_addr,       32'h8);
    tick();
    chk("e4_pc",    inst_pc,         32'h8);
    chk("e4_addr",  imem_addr,       32'hC);

    // Stall for 5 cycles: queue fills, request stops, head frozen
    stall = 1'b1;
    tick();
    chk("st1_req",  32'(imem_req),   32'd0);
    chk("st1_pc",   inst_pc,         32'h8);
    chk("st1_addr", imem_addr,       32'h10);
    tick(); tick(); tick(); tick();
    chk("st5_req",   32'(imem_req),   32'd0);
    chk("st5_pc",    inst_pc,         32'h8);
    chk("st5_inst",  inst,            32'h1234_0008);
    chk("st5_valid", 32'(inst_valid), 32'd1);
    stall = 1'b0;
    tick();
    chk("rel1_pc",    inst_pc,         32'hC);
    chk("rel1_valid", 32'(inst_valid), 32'd1);
    chk("rel1_req",   32'(imem_req),   32'd1);
    chk("rel1_addr",  imem_addr,       32'h10);
    tick();
    chk("rel2_pc",    inst_pc,         32'h10);
    chk("rel2_valid", 32'(inst_valid), 32'd1);
    chk("rel2_addr",  imem_addr,       32'h14);

    // Ack withheld for three cycles: request held stable, queue drains
    ack_en = 1'b0;
    tick();
    chk("slow1_valid", 32'(inst_valid), 32'd0);
    chk("slow1_req",   32'(imem_req),   32'd1);
    chk("slow1_addr",  imem_addr,       32'h14);
    tick();
    chk("slow2_valid", 32'(inst_valid), 32'd0);
    chk("slow2_addr",  imem_addr,       32'h14);
    tick();
    chk("slow3_valid", 32'(inst_valid), 32'd0);
    chk("slow3_req",   32'(imem_req),   32'd1);
    chk("slow3_addr",  imem_addr,       32'h14);
    ack_en = 1'b1;
    tick();
    chk("slow4_valid", 32'(inst_valid), 32'd1);
    chk("slow4_pc",    inst_pc,         32'h14);
    chk("slow4_addr",  imem_addr,       32'h18);

    // Asynchronous reset in the middle of a request
    ack_en = 1'b0;
    #2; rst = 1'b0; #1;
    chk("arst_req",   32'(imem_req),   32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    chk("arst_addr",  imem_addr,       32'h0);
    @(negedge clk); rst = 1'b1; ack_en = 1'b1;
    tick();
    tick();
    chk("r2_pc", inst_pc, 32'h0);
    tick();
    chk("r3_pc",   inst_pc,   32'h4);
    chk("r3_addr", imem_addr, 32'h8);

    // Redirect to 0x100 while the 0x8 request is pending; ack two cycles later
    ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("rd1_valid", 32'(inst_valid), 32'd0);
    chk("rd1_req",   32'(imem_req),   32'd1);
    chk("rd1_addr",  imem_addr,       32'h8);
    redirect = 1'b0;
    tick();
    chk("rd2_addr",  imem_addr,       32'h8);
    chk("rd2_valid", 32'(inst_valid), 32'd0);
    ack_en = 1'b1;
    tick();
    chk("rd3_addr",  imem_addr,       32'h100);
    chk("rd3_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("rd4_valid", 32'(inst_valid), 32'd1);
    chk("rd4_pc",    inst_pc,         32'h100);
    chk("rd4_inst",  inst,            32'h1234_0100);
    chk("rd4_addr",  imem_addr,       32'h104);

    // Redirect together with stall on a full queue
    stall = 1'b1;
    tick();
    chk("rs1_req", 32'(imem_req), 32'd0);
    chk("rs1_pc",  inst_pc,       32'h100);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("rs2_valid", 32'(inst_valid), 32'd0);
    chk("rs2_req",   32'(imem_req),   32'd1);
    chk("rs2_addr",  imem_addr,       32'h200);
    redirect = 1'b0; stall = 1'b0;
    tick();
    chk("rs3_valid", 32'(inst_valid), 32'd1);
    chk("rs3_pc",    inst_pc,         32'h200);

    // Redirect with ack in the same cycle, to the top word of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk("wr1_addr",  imem_addr,       32'hFFFF_FFFC);
    chk("wr1_valid", 32'(inst_valid), 32'd0);
    redirect = 1'b0;
    tick();
    chk("wr2_valid", 32'(inst_valid), 32'd1);
    chk("wr2_pc",    inst_pc,         32'hFFFF_FFFC);
    chk("wr2_pc4",   pc_plus4,        32'h0);
    chk("wr2_addr",  imem_addr,       32'h0);
    tick();
    chk("wr3_pc",   inst_pc,  32'h0);
    chk("wr3_inst", inst,     32'h1234_0000);
    chk("wr3_pc4",  pc_plus4, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the MIPS pipeline. It owns the program counter, issues instruction-memory reads over a req/ack handshake, and buffers returned words in a small queue. It presents one instruction at a time, with its PC, to the IF/ID register. It absorbs the ID-stage branch/jump redirect and the hazard-unit stall, so variable instruction-memory latency never reaches the datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, queue entries; power of two, at least 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- stall  in  1  hazard unit holds IF/ID; head entry is not consumed
- redirect  in  1  branch/jump taken in ID (pcSrc != 0)
- redirect_pc  in  32  branch or jump target
- imem_req  out  1  read request, held until ack
- imem_addr  out  32  word address; stable while imem_req=1
- imem_ack  in  1  read complete this cycle
- imem_rdata  in  32  instruction; valid only when imem_ack=1
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction
- inst_pc  out  32  PC of queue head
- pc_plus4  out  32  inst_pc + 4, wraps mod 2^32

## Operation
- The queue holds {instr, pc} entries in a count register 0..DEPTH. The head drives inst, inst_pc and inst_valid (count != 0).
- Pop condition: inst_valid & ~stall & ~redirect.
- Push condition: imem_ack in WAIT and ~redirect. The issue rule keeps count + outstanding ≤ DEPTH, so a push never overflows, including a simultaneous push and pop when the queue is full.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; the result is kept.
  - DISCARD: request outstanding; the result is dropped.
- imem_req = (state != IDLE).
- fetch_pc: addition is 32-bit and wraps; bits [1:0] pass through unchanged.
- IDLE transitions:
  - redirect → WAIT, fetch_pc := redirect_pc.
  - Otherwise, if count_next < DEPTH → WAIT.
- WAIT transitions:
  - redirect & imem_ack → WAIT, fetch_pc := redirect_pc; response dropped.
  - redirect & ~imem_ack → DISCARD, fetch_pc := redirect_pc.
  - imem_ack → push, fetch_pc += 4, then WAIT if count_next < DEPTH, else IDLE.
- DISCARD transitions:
  - imem_ack → WAIT; the request goes out at fetch_pc, and the response is not pushed.
  - redirect → fetch_pc := redirect_pc; stays DISCARD.
- Redirect flushes the queue: count := 0 and inst_valid drops on the next cycle. Redirect has priority over stall and over push.
- An outstanding request is never aborted. imem_addr is held until ack, even after a redirect.
- Stall freezes the head only. Fetching continues until the queue is full.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, pc_plus4=4, state=IDLE, count=0.
- Reset assertion takes effect immediately (asynchronous). Asserting reset mid-request drops the request; the memory must tolerate an abandoned req.
- First edge after reset release: IDLE→WAIT, so imem_req rises.
- An ack in cycle N makes inst_valid=1 in cycle N+1.
- Zero-wait memory (ack tied high while req is asserted) gives one instruction per cycle.
- Redirect in cycle N with ack in the same cycle: imem_addr=redirect_pc in cycle N+1, and the first new instruction is valid in N+2 at the earliest.
- Outputs depend only on registers; there is no combinational path from input to output.

## Structure
- Package mips_pkg holds:
  - fetch_state_t enum {IDLE, WAIT, DISCARD}
  - INSTR_W=32 and ADDR_W=32
  - NOP_INSTR=32'h0000_0000
  - PC_STEP=4
- Sub-module fetch_queue holds the DEPTH-entry FIFO with push, pop, flush, count, head outputs and an asynchronous active-low reset. fetch_unit holds the FSM and fetch_pc.

## Test plan
- Reset release, ack tied to 1: imem_addr sequence is 0,4,8,12; inst_valid rises two edges after release; inst_pc follows 0,4,8 on consecutive cycles.
- Stall held for 5 cycles with zero-wait memory: count saturates at 2, imem_req drops, and inst/inst_pc are frozen. When stall releases, the next three instructions appear in order with no gap after the first.
- Ack delayed 3 cycles: imem_req and imem_addr stay stable; inst_valid is 0 until the cycle after ack.
- Redirect to 0x100 while a request to 0x8 is pending (ack 2 cycles later): the 0x8 data is never output, imem_addr is 0x100 after the ack, and the first valid inst_pc is 0x100.
- Redirect together with stall, with a full queue: the queue is flushed next cycle, inst_valid=0, and fetch restarts at redirect_pc.
- fetch_pc=32'hFFFF_FFFC fetched: the next imem_addr is 0, and pc_plus4 for that entry is 0.
